miller_frame_rx: RTL and testbench
==================================

Name: miller_frame_rx

Overview:
- Downstream stage of the Miller decoder in the tag-to-reader receive path.
- Consumes the decoded bit stream: one bit per `bit_valid` strobe.
- Hunts for the Gen2 preamble, deserializes a fixed-length frame MSB-first and checks its CRC-16.
- Presents the frame word plus `crc_ok` to the protocol controller as a one-cycle `frame_valid` pulse.

Parameters:
- PRE_LEN, 6: preamble length in decoded bits.
- PREAMBLE, 6'b010111: preamble pattern; leftmost bit is received first.
- FRAME_BITS, 32: bits collected after the preamble, CRC field included (minimum 17).
- TIMEOUT, 255: maximum clk cycles between consecutive `bit_valid` strobes while collecting.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous reset, active-high.
- bit_in  in  1  decoded bit from the Miller decoder.
- bit_valid  in  1  one-cycle strobe; `bit_in` is valid on this cycle.
- frame_data  out  FRAME_BITS  received frame; first bit lands in the MSB.
- frame_valid  out  1  one-cycle pulse; `frame_data` and `crc_ok` are valid.
- crc_ok  out  1  1 when the CRC residue equals 16'h1D0F.
- frame_err  out  1  one-cycle pulse on an inter-bit timeout abort.
- busy  out  1  high while in COLLECT.

Behaviour:
- Reset: registers take these values on a clock edge with rst=1, regardless of other inputs.
  - state=HUNT; pre_sr=0; bit_cnt=0; crc=16'hFFFF; gap_cnt=0.
  - frame_data=0; frame_valid=0; crc_ok=0; frame_err=0; busy=0.
- States: HUNT and COLLECT; `busy` = (state==COLLECT), registered.
- HUNT:
  - On `bit_valid`: pre_sr <= {pre_sr[PRE_LEN-2:0], bit_in}.
  - The match check uses the shifted value. On match: go to COLLECT with bit_cnt=0, crc=16'hFFFF, gap_cnt=0, shift register cleared.
  - Overlapping prefixes must be found. Example: 0,1,0,1,0,1,1,1 matches on the 8th bit.
- COLLECT, on `bit_valid`:
  - Shift `bit_in` into the frame shift register.
  - Update CRC: fb = crc[15]^bit_in; crc <= {crc[14:0],1'b0} ^ (fb ? 16'h1021 : 0).
  - bit_cnt++ and gap_cnt <= 0.
- COLLECT, on the bit where bit_cnt==FRAME_BITS-1:
  - Load `frame_data` with the completed shift value.
  - crc_ok <= (updated crc == 16'h1D0F).
  - Pulse `frame_valid`; return to HUNT with pre_sr=0.
- Latency: `frame_valid` is high in the cycle immediately after the edge that samples the last bit.
- Hold behaviour:
  - `frame_data` and `crc_ok` hold until the next frame completes or until reset.
  - `frame_valid` and `frame_err` are single-cycle pulses.
- Timeout:
  - In COLLECT with no `bit_valid`, gap_cnt increments each cycle.
  - When gap_cnt reaches TIMEOUT: pulse `frame_err`, return to HUNT with pre_sr=0, leave `frame_data` and `crc_ok` unchanged.
  - If `bit_valid` arrives on the same cycle gap_cnt would reach TIMEOUT, the bit wins and there is no abort.
- Bit rules:
  - `bit_valid` strobes may be back-to-back, every cycle.
  - The bit that completes a frame is never reused for preamble search.
  - The next frame needs a full new preamble.
- Reset mid-frame: the partial frame is discarded. No `frame_valid` or `frame_err` pulse follows.
- `bit_in` is ignored when `bit_valid`=0.

Test Plan:
- Clean frame with bits spaced 4 cycles:
  - Stimulus: preamble 010111, payload 16'h0000, CRC field 16'hE2F0.
  - Response: exactly one `frame_valid` pulse one cycle after the last strobe, with frame_data=32'h0000E2F0 and crc_ok=1.
- Corrupted CRC: same frame with bit 0 flipped, frame 32'h0000E2F1 → frame_valid=1, crc_ok=0, frame_data=32'h0000E2F1.
- Overlapping and back-to-back preambles:
  - Noise 0101 then 010111 then the clean frame, strobes every cycle → single pulse, correct data.
  - Two clean frames back-to-back → two pulses, the second only after its own preamble.
- Timeout:
  - Preamble plus 10 bits, then silence → frame_err pulses exactly TIMEOUT cycles after the 10th strobe; busy falls; frame_data unchanged.
  - Strobe on the TIMEOUT-th gap cycle → no abort.
- Reset mid-frame:
  - Assert rst for 1 cycle after 20 frame bits, then send the clean frame → all outputs 0 after reset.
  - No pulse from the partial frame; one valid pulse with crc_ok=1 for the new frame.
- Ignored input: toggling `bit_in` with bit_valid=0 for 100 cycles in HUNT → no state change, busy=0.

Source files
------------

// File: rtl/miller_frame_rx.sv
// miller_frame_rx: hunts the Gen2 preamble in the decoded Miller bit stream,
// deserializes a fixed-length frame MSB-first, checks its CRC-16 residue and
// reports the frame with a one-cycle frame_valid pulse. A frame that stalls
// for TIMEOUT cycles between bits is aborted with a frame_err pulse.
//
// Input handshake: bit_in is a qualified sample only on cycles where
// bit_valid=1; there is no back-pressure, and strobes may arrive every cycle.
// frame_valid/frame_err are single-cycle pulses; frame_data/crc_ok hold
// until the next completed frame. busy is the registered FSM state
// (1 = COLLECT) and doubles as the state debug view.
module miller_frame_rx #(
    parameter int                 PRE_LEN    = 6,
    parameter logic [PRE_LEN-1:0] PREAMBLE   = 6'b010111,
    parameter int                 FRAME_BITS = 32,
    parameter int                 TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  bit_in,
    input  logic                  bit_valid,
    output logic [FRAME_BITS-1:0] frame_data,
    output logic                  frame_valid,
    output logic                  crc_ok,
    output logic                  frame_err,
    output logic                  busy
);

    localparam int BW = $clog2(FRAME_BITS);
    localparam int GW = $clog2(TIMEOUT + 1);

    localparam logic [15:0]   CRC_INIT    = 16'hFFFF;
    localparam logic [15:0]   CRC_POLY    = 16'h1021;
    localparam logic [15:0]   CRC_RESIDUE = 16'h1D0F;
    localparam logic [BW-1:0] LAST_BIT    = BW'(FRAME_BITS - 1);
    localparam logic [GW-1:0] GAP_LIMIT   = GW'(TIMEOUT);

    typedef enum logic {
        HUNT    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [PRE_LEN-1:0]      pre_sr_q, pre_sr_d;
    logic [BW-1:0]           bit_cnt_q, bit_cnt_d;
    logic [15:0]             crc_q, crc_d;
    logic [GW-1:0]           gap_cnt_q, gap_cnt_d;
    logic [FRAME_BITS-1:0]   shift_q, shift_d;
    logic [FRAME_BITS-1:0]   frame_data_q, frame_data_d;
    logic                    frame_valid_q, frame_valid_d;
    logic                    crc_ok_q, crc_ok_d;
    logic                    frame_err_q, frame_err_d;
    logic                    busy_q, busy_d;

    logic [PRE_LEN-1:0]      pre_shift;
    logic                    crc_fb;
    logic [15:0]             crc_upd;
    logic [FRAME_BITS-1:0]   shift_upd;
    logic [GW-1:0]           gap_inc;

    // Next-state and output logic; the match test looks at the already-shifted
    // preamble window so overlapping prefixes are found on the right bit.
    always_comb begin
        state_d       = state_q;
        pre_sr_d      = pre_sr_q;
        bit_cnt_d     = bit_cnt_q;
        crc_d         = crc_q;
        gap_cnt_d     = gap_cnt_q;
        shift_d       = shift_q;
        frame_data_d  = frame_data_q;
        crc_ok_d      = crc_ok_q;
        frame_valid_d = 1'b0;
        frame_err_d   = 1'b0;

        pre_shift = {pre_sr_q[PRE_LEN-2:0], bit_in};
        crc_fb    = crc_q[15] ^ bit_in;
        crc_upd   = {crc_q[14:0], 1'b0} ^ (crc_fb ? CRC_POLY : 16'h0000);
        shift_upd = {shift_q[FRAME_BITS-2:0], bit_in};
        gap_inc   = gap_cnt_q + 1'b1;

        unique case (state_q)
            HUNT: begin
                if (bit_valid) begin
                    pre_sr_d = pre_shift;
                    if (pre_shift == PREAMBLE) begin
                        state_d   = COLLECT;
                        pre_sr_d  = '0;
                        bit_cnt_d = '0;
                        crc_d     = CRC_INIT;
                        gap_cnt_d = '0;
                        shift_d   = '0;
                    end
                end
            end
            COLLECT: begin
                if (bit_valid) begin
                    // A bit on the would-be timeout cycle still counts.
                    shift_d   = shift_upd;
                    crc_d     = crc_upd;
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    gap_cnt_d = '0;
                    if (bit_cnt_q == LAST_BIT) begin
                        frame_data_d  = shift_upd;
                        crc_ok_d      = (crc_upd == CRC_RESIDUE);
                        frame_valid_d = 1'b1;
                        state_d       = HUNT;
                        pre_sr_d      = '0;
                        bit_cnt_d     = '0;
                    end
                end else begin
                    gap_cnt_d = gap_inc;
                    if (gap_inc == GAP_LIMIT) begin
                        frame_err_d = 1'b1;
                        state_d     = HUNT;
                        pre_sr_d    = '0;
                    end
                end
            end
            default: state_d = HUNT;
        endcase

        busy_d = (state_d == COLLECT);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= HUNT;
            pre_sr_q      <= '0;
            bit_cnt_q     <= '0;
            crc_q         <= CRC_INIT;
            gap_cnt_q     <= '0;
            shift_q       <= '0;
            frame_data_q  <= '0;
            frame_valid_q <= 1'b0;
            crc_ok_q      <= 1'b0;
            frame_err_q   <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            pre_sr_q      <= pre_sr_d;
            bit_cnt_q     <= bit_cnt_d;
            crc_q         <= crc_d;
            gap_cnt_q     <= gap_cnt_d;
            shift_q       <= shift_d;
            frame_data_q  <= frame_data_d;
            frame_valid_q <= frame_valid_d;
            crc_ok_q      <= crc_ok_d;
            frame_err_q   <= frame_err_d;
            busy_q        <= busy_d;
        end
    end

    assign frame_data  = frame_data_q;
    assign frame_valid = frame_valid_q;
    assign crc_ok      = crc_ok_q;
    assign frame_err   = frame_err_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_miller_frame_rx.sv
// Testbench for miller_frame_rx: directed scenarios plus randomized frames,
// checked against a bit-event reference model of the receiver.
module tb_miller_frame_rx;

    localparam int         PRE_LEN    = 6;
    localparam logic [5:0] PREAMBLE   = 6'b010111;
    localparam int         FRAME_BITS = 32;
    localparam int         TIMEOUT    = 255;

    logic                  clk;
    logic                  rst;
    logic                  bit_in;
    logic                  bit_valid;
    logic [FRAME_BITS-1:0] frame_data;
    logic                  frame_valid;
    logic                  crc_ok;
    logic                  frame_err;
    logic                  busy;

    int n_checks = 0;
    int n_fail   = 0;
    int n_fv     = 0;
    int n_fe     = 0;

    // reference model state
    bit          m_collect;
    bit          m_win[$];
    int          m_cnt;
    int          m_gap;
    logic [31:0] m_acc;
    logic [31:0] m_data;
    logic        m_crc_ok;
    logic        exp_fv;
    logic        exp_fe;
    logic [31:0] exp_q[$];

    miller_frame_rx #(
        .PRE_LEN    (PRE_LEN),
        .PREAMBLE   (PREAMBLE),
        .FRAME_BITS (FRAME_BITS),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bit_in      (bit_in),
        .bit_valid   (bit_valid),
        .frame_data  (frame_data),
        .frame_valid (frame_valid),
        .crc_ok      (crc_ok),
        .frame_err   (frame_err),
        .busy        (busy)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // watchdog
    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // CRC-16 register after feeding the n low bits of w, MSB first.
    function automatic logic [15:0] crc_word(input logic [15:0] init, input logic [31:0] w, input int n);
        logic [15:0] c;
        c = init;
        for (int i = n - 1; i >= 0; i--) begin
            if (c[15] ^ w[i]) c = (c << 1) ^ 16'h1021;
            else              c = c << 1;
        end
        return c;
    endfunction

    task automatic model_clear_window();
        m_win.delete();
        for (int i = 0; i < PRE_LEN; i++) m_win.push_back(1'b0);
    endtask

    task automatic model_reset();
        m_collect = 1'b0;
        m_cnt     = 0;
        m_gap     = 0;
        m_acc     = '0;
        m_data    = '0;
        m_crc_ok  = 1'b0;
        exp_fv    = 1'b0;
        exp_fe    = 1'b0;
        model_clear_window();
    endtask

    // One clock of the receiver as seen from outside: bit events and gaps.
    task automatic model_step(input logic v, input logic b);
        logic [5:0] pat;
        bit         hit;
        pat    = PREAMBLE;
        exp_fv = 1'b0;
        exp_fe = 1'b0;
        if (!m_collect) begin
            if (v) begin
                void'(m_win.pop_front());
                m_win.push_back(b);
                hit = 1'b1;
                for (int i = 0; i < PRE_LEN; i++)
                    if (m_win[i] != pat[PRE_LEN-1-i]) hit = 1'b0;
                if (hit) begin
                    m_collect = 1'b1;
                    m_cnt     = 0;
                    m_acc     = '0;
                    m_gap     = 0;
                    model_clear_window();
                end
            end
        end else if (v) begin
            m_acc = m_acc * 2 + 32'(b);
            m_cnt++;
            m_gap = 0;
            if (m_cnt == FRAME_BITS) begin
                m_data    = m_acc;
                m_crc_ok  = (crc_word(16'hFFFF, m_acc, FRAME_BITS) == 16'h1D0F);
                exp_q.push_back(m_acc);
                exp_fv    = 1'b1;
                m_collect = 1'b0;
                model_clear_window();
            end
        end else begin
            m_gap++;
            if (m_gap == TIMEOUT) begin
                exp_fe    = 1'b1;
                m_collect = 1'b0;
                model_clear_window();
            end
        end
    endtask

    // scoreboard: compare all outputs after every clock
    task automatic check_outputs();
        logic [31:0] w;
        check("frame_valid", 32'(frame_valid), 32'(exp_fv));
        check("frame_err", 32'(frame_err), 32'(exp_fe));
        check("busy", 32'(busy), 32'(m_collect));
        if (frame_valid) begin
            n_fv++;
            check("exp_q_depth", exp_q.size(), 1);
            if (exp_q.size() > 0) begin
                w = exp_q.pop_front();
                check("frame_data_pulse", frame_data, w);
            end
        end
        if (frame_err) n_fe++;
        check("frame_data_hold", frame_data, m_data);
        check("crc_ok", 32'(crc_ok), 32'(m_crc_ok));
    endtask

    // driver: one clock with or without a strobe; called at a negedge
    task automatic cycle(input logic v, input logic b);
        bit_valid = v;
        bit_in    = b;
        @(posedge clk);
        model_step(v, b);
        @(negedge clk);
        bit_valid = 1'b0;
        bit_in    = 1'($urandom_range(0, 1));
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'($urandom_range(0, 1)));
    endtask

    task automatic send_word(input logic [31:0] w, input int n, input int gap_min, input int gap_max);
        for (int i = n - 1; i >= 0; i--) begin
            cycle(1'b1, w[i]);
            if (i > 0) idle($urandom_range(gap_min, gap_max));
        end
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        bit_valid = 1'b1;
        bit_in    = 1'b1;
        @(posedge clk);
        model_reset();
        exp_q.delete();
        @(negedge clk);
        rst       = 1'b0;
        bit_valid = 1'b0;
        bit_in    = 1'b0;
        check("rst_frame_data", frame_data, 32'h0);
        check("rst_frame_valid", 32'(frame_valid), 32'h0);
        check("rst_crc_ok", 32'(crc_ok), 32'h0);
        check("rst_frame_err", 32'(frame_err), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
    endtask

    initial begin
        int          k;
        int          fv0;
        int          fe0;
        logic [31:0] held;
        logic [15:0] payload;
        logic [15:0] fcs;

        rst       = 1'b1;
        bit_valid = 1'b0;
        bit_in    = 1'b0;
        model_reset();
        @(negedge clk);
        do_reset();

        // clean frame, strobes every 4 cycles
        fv0 = n_fv;
        send_word(32'(PREAMBLE), PRE_LEN, 3, 3);
        idle(3);
        send_word(32'h0000E2F0, 32, 3, 3);
        check("clean_data", frame_data, 32'h0000E2F0);
        check("clean_crc_ok", 32'(crc_ok), 32'h1);
        idle(4);
        check("clean_pulses", n_fv - fv0, 1);

        // corrupted CRC
        send_word(32'(PREAMBLE), PRE_LEN, 3, 3);
        send_word(32'h0000E2F1, 32, 3, 3);
        check("bad_data", frame_data, 32'h0000E2F1);
        check("bad_crc_ok", 32'(crc_ok), 32'h0);
        idle(2);

        // noise 0101 then overlapping preamble, back-to-back strobes
        fv0 = n_fv;
        send_word(32'h5, 4, 0, 0);
        send_word(32'(PREAMBLE), PRE_LEN, 0, 0);
        send_word(32'h0000E2F0, 32, 0, 0);
        check("overlap_data", frame_data, 32'h0000E2F0);
        check("overlap_crc_ok", 32'(crc_ok), 32'h1);

        // two frames back-to-back, each with its own preamble
        send_word(32'(PREAMBLE), PRE_LEN, 0, 0);
        send_word(32'h0000E2F1, 32, 0, 0);
        send_word(32'(PREAMBLE), PRE_LEN, 0, 0);
        send_word(32'h0000E2F0, 32, 0, 0);
        check("b2b_data", frame_data, 32'h0000E2F0);
        idle(2);
        check("overlap_b2b_pulses", n_fv - fv0, 3);

        // timeout: preamble + 10 bits, then silence
        held = frame_data;
        fe0  = n_fe;
        send_word(32'(PREAMBLE), PRE_LEN, 0, 0);
        send_word(32'($urandom_range(0, 1023)), 10, 0, 0);
        k = 0;
        for (int i = 1; i <= 2 * TIMEOUT; i++) begin
            cycle(1'b0, 1'($urandom_range(0, 1)));
            if (frame_err) begin
                k = i;
                break;
            end
        end
        check("timeout_gap", k, TIMEOUT);
        check("timeout_busy", 32'(busy), 32'h0);
        check("timeout_data_kept", frame_data, held);
        check("timeout_pulses", n_fe - fe0, 1);

        // strobe on the TIMEOUT-th gap cycle keeps the frame alive
        fv0 = n_fv;
        fe0 = n_fe;
        send_word(32'(PREAMBLE), PRE_LEN, 0, 0);
        send_word(32'h0, 10, 0, 0);
        idle(TIMEOUT - 1);
        send_word(32'h0000E2F0, 22, 0, 0);
        check("late_bit_data", frame_data, 32'h0000E2F0);
        check("late_bit_crc_ok", 32'(crc_ok), 32'h1);
        check("late_bit_no_abort", n_fe - fe0, 0);
        check("late_bit_pulses", n_fv - fv0, 1);

        // reset mid-frame, then a clean frame
        send_word(32'(PREAMBLE), PRE_LEN, 0, 0);
        send_word(32'($urandom()), 20, 0, 1);
        do_reset();
        fv0 = n_fv;
        fe0 = n_fe;
        send_word(32'(PREAMBLE), PRE_LEN, 0, 2);
        send_word(32'h0000E2F0, 32, 0, 2);
        check("post_rst_crc_ok", 32'(crc_ok), 32'h1);
        idle(TIMEOUT + 2);
        check("post_rst_pulses", n_fv - fv0, 1);
        check("post_rst_no_err", n_fe - fe0, 0);

        // ignored input in HUNT
        for (int i = 0; i < 100; i++) begin
            cycle(1'b0, 1'($urandom_range(0, 1)));
            check("ignored_busy", 32'(busy), 32'h0);
        end

        // randomized frames: noise, preamble, payload with good or bad CRC
        for (int f = 0; f < 40; f++) begin
            send_word(32'($urandom()), $urandom_range(1, 8), 0, 2);
            send_word(32'(PREAMBLE), PRE_LEN, 0, 3);
            payload = 16'($urandom());
            fcs     = ~crc_word(16'hFFFF, 32'(payload), 16);
            if ($urandom_range(0, 1) == 1) fcs = fcs ^ 16'(1 << $urandom_range(0, 15));
            send_word({payload, fcs}, 32, 0, 3);
            idle($urandom_range(0, 3));
        end
        idle(TIMEOUT + 2);

        check("exp_q_leftover", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
